// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle between the pipeline datapath and its hazard/memory
// controller.
//   master : pipeline side. Drives the ID/EX/MEM hazard inputs and dmem_ack,
//            and receives the stall/flush controls and status.
//   slave  : controller side (pipe_ctrl).
// Ports:
//   id_rs1, id_rs2           ID-stage source register addresses
//   id_uses_rs1, id_uses_rs2 ID instruction really reads rs1/rs2
//   ex_rd, ex_reg_wen,
//   ex_mem_ren,
//   ex_branch_taken          EX destination, write-enable, load flag, redirect
//   mem_access               MEM-stage instruction is a load or store
//   dmem_ack                 data memory completes the access this cycle
//   dmem_req                 data memory request, held until ack
//   stall_*                  hold the PC / pipeline register
//   flush_*                  turn the pipeline register into a bubble
//   mem_timeout              sticky watchdog error
//   stall_cycles             number of cycles with stall_pc=1
interface pipe_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  ex_rd;
  logic        ex_reg_wen;
  logic        ex_mem_ren;
  logic        ex_branch_taken;
  logic        mem_access;
  logic        dmem_ack;
  logic        dmem_req;
  logic        stall_pc;
  logic        stall_ifid;
  logic        stall_idex;
  logic        stall_exmem;
  logic        flush_ifid;
  logic        flush_idex;
  logic        flush_memwb;
  logic        mem_timeout;
  logic [31:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_rd, ex_reg_wen, ex_mem_ren, ex_branch_taken,
           mem_access, dmem_ack,
    input  dmem_req, stall_pc, stall_ifid, stall_idex, stall_exmem,
           flush_ifid, flush_idex, flush_memwb, mem_timeout, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_rd, ex_reg_wen, ex_mem_ren, ex_branch_taken,
           mem_access, dmem_ack,
    output dmem_req, stall_pc, stall_ifid, stall_idex, stall_exmem,
           flush_ifid, flush_idex, flush_memwb, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller with a data-memory wait FSM and
// watchdog. Resolves memory wait stalls, EX redirects and load-use hazards
// into per-register stall/flush controls (priority mem wait > redirect >
// load-use) and counts stalled cycles.
// Ports:
//   clk  single clock, posedge
//   rst  synchronous active-high reset
//   bus  pipe_ctrl_if.slave (hazard inputs, dmem handshake, controls, status)
// Parameter:
//   TIMEOUT  maximum dmem wait cycles (1..255) before the watchdog aborts
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no access outstanding; a MEM access without ack starts a wait
// WAIT   | access outstanding, dmem_req held, wait_cnt counts wait cycles
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  logic [0:0]  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  logic mem_stall;
  logic load_use;
  logic cnt_expired;

  logic dmem_req;
  logic stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic flush_ifid, flush_idex, flush_memwb;

  assign cnt_expired = (wait_cnt_q == TO_CNT);

  // An expired wait is not a stall: that cycle is the abort, and the
  // pipeline advances as though the access had been acknowledged.
  assign mem_stall =
      ((state_q == S_IDLE) & bus.mem_access & ~bus.dmem_ack) |
      ((state_q == S_WAIT) & ~bus.dmem_ack & ~cnt_expired);

  assign load_use = bus.ex_mem_ren & bus.ex_reg_wen & (bus.ex_rd != 5'd0) &
                    ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                     (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_access && !bus.dmem_ack) begin
          state_d    = S_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      S_WAIT: begin
        if (bus.dmem_ack) begin
          state_d    = S_IDLE;
          wait_cnt_d = 8'd0;
        end else if (cnt_expired) begin
          state_d       = S_IDLE;
          wait_cnt_d    = 8'd0;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // While a mem stall holds EX, a taken branch simply stays in EX and is
  // acted on here on the first cycle the stall clears.
  always_comb begin
    dmem_req    = 1'b0;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_memwb = 1'b0;
    if (!rst) begin
      dmem_req = (state_q == S_WAIT) | bus.mem_access;
      if (mem_stall) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
        flush_memwb = 1'b1;
      end else if (bus.ex_branch_taken) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end else if (load_use) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
      end
    end
  end

  // Wraps naturally at 32 bits.
  assign stall_cycles_d = stall_cycles_q + {31'd0, stall_pc};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wait_cnt_q     <= 8'd0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.dmem_req     = dmem_req;
  assign bus.stall_pc     = stall_pc;
  assign bus.stall_ifid   = stall_ifid;
  assign bus.stall_idex   = stall_idex;
  assign bus.stall_exmem  = stall_exmem;
  assign bus.flush_ifid   = flush_ifid;
  assign bus.flush_idex   = flush_idex;
  assign bus.flush_memwb  = flush_memwb;
  assign bus.mem_timeout  = mem_timeout_q;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl (TIMEOUT=4).
// Control outputs are compared as one packed vector:
//   {dmem_req, stall_pc, stall_ifid, stall_idex, stall_exmem,
//    flush_ifid, flush_idex, flush_memwb}
module tb_pipe_ctrl;

  localparam logic [7:0] C_NONE  = 8'b0_0000_000;
  localparam logic [7:0] C_REQ   = 8'b1_0000_000;
  localparam logic [7:0] C_MEMST = 8'b1_1111_001;
  localparam logic [7:0] C_LU    = 8'b0_1100_010;
  localparam logic [7:0] C_BR    = 8'b0_0000_110;
  localparam logic [7:0] C_REQBR = 8'b1_0000_110;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  pipe_ctrl_if ifc ();

  pipe_ctrl #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  wire [7:0] ctl = {ifc.dmem_req, ifc.stall_pc, ifc.stall_ifid, ifc.stall_idex,
                    ifc.stall_exmem, ifc.flush_ifid, ifc.flush_idex,
                    ifc.flush_memwb};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Checks the combinational controls mid-cycle, then advances one clock.
  task automatic step(input string tag, input logic [7:0] exp_ctl);
    #4;
    check(tag, {24'd0, ctl}, {24'd0, exp_ctl});
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ifc.id_rs1          = 5'd0;
    ifc.id_rs2          = 5'd0;
    ifc.id_uses_rs1     = 1'b0;
    ifc.id_uses_rs2     = 1'b0;
    ifc.ex_rd           = 5'd0;
    ifc.ex_reg_wen      = 1'b0;
    ifc.ex_mem_ren      = 1'b0;
    ifc.ex_branch_taken = 1'b0;
    ifc.mem_access      = 1'b0;
    ifc.dmem_ack        = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ifc.ex_mem_ren  = 1'b1;
    ifc.ex_reg_wen  = 1'b1;
    ifc.ex_rd       = rd;
    ifc.id_rs1      = rd;
    ifc.id_uses_rs1 = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    clear_in();

    // reset: outputs forced low even with hazards present
    rst = 1'b1;
    ifc.mem_access      = 1'b1;
    ifc.ex_branch_taken = 1'b1;
    step("rst_ctl", C_NONE);
    rst = 1'b0;
    clear_in();
    check("rst_sc", ifc.stall_cycles, 32'd0);
    check("rst_to", {31'd0, ifc.mem_timeout}, 32'd0);

    // load x5 in EX, ID reads rs1=5
    set_load_use(5'd5);
    step("lu_rs1", C_LU);
    check("lu_rs1_sc", ifc.stall_cycles, 32'd1);
    ifc.ex_mem_ren = 1'b0;
    step("lu_after", C_NONE);
    check("lu_after_sc", ifc.stall_cycles, 32'd1);

    // rs2 match, then same match with id_uses_rs2=0
    clear_in();
    ifc.ex_mem_ren  = 1'b1;
    ifc.ex_reg_wen  = 1'b1;
    ifc.ex_rd       = 5'd7;
    ifc.id_rs2      = 5'd7;
    ifc.id_uses_rs2 = 1'b1;
    step("lu_rs2", C_LU);
    ifc.id_uses_rs2 = 1'b0;
    step("lu_rs2_unused", C_NONE);

    // load to x0 never stalls
    clear_in();
    set_load_use(5'd0);
    step("lu_x0", C_NONE);
    // non-writing load never stalls
    set_load_use(5'd9);
    ifc.ex_reg_wen = 1'b0;
    step("lu_nowen", C_NONE);
    check("lu_sc", ifc.stall_cycles, 32'd2);

    // mem access, ack after 3 wait cycles
    clear_in();
    ifc.mem_access = 1'b1;
    step("mw_0", C_MEMST);
    step("mw_1", C_MEMST);
    step("mw_2", C_MEMST);
    ifc.dmem_ack = 1'b1;
    step("mw_ack", C_REQ);
    check("mw_sc", ifc.stall_cycles, 32'd5);
    // back-to-back access starts from IDLE
    ifc.dmem_ack = 1'b0;
    step("b2b_0", C_MEMST);
    ifc.dmem_ack = 1'b1;
    step("b2b_ack", C_REQ);
    // single-cycle access acked immediately
    step("imm_ack", C_REQ);
    clear_in();
    step("mw_idle", C_NONE);
    check("b2b_sc", ifc.stall_cycles, 32'd6);

    // redirect + load-use during a 2-cycle mem wait
    set_load_use(5'd3);
    ifc.ex_branch_taken = 1'b1;
    ifc.mem_access      = 1'b1;
    step("brw_0", C_MEMST);
    step("brw_1", C_MEMST);
    ifc.dmem_ack = 1'b1;
    step("brw_ack", C_REQBR);
    ifc.mem_access = 1'b0;
    ifc.dmem_ack   = 1'b0;
    step("br_lu", C_BR);
    clear_in();
    step("br_idle", C_NONE);
    check("br_sc", ifc.stall_cycles, 32'd8);

    // watchdog: no ack, TIMEOUT=4
    ifc.mem_access = 1'b1;
    step("to_0", C_MEMST);
    step("to_1", C_MEMST);
    step("to_2", C_MEMST);
    step("to_3", C_MEMST);
    check("to_pre", {31'd0, ifc.mem_timeout}, 32'd0);
    step("to_abort", C_REQ);
    check("to_set", {31'd0, ifc.mem_timeout}, 32'd1);
    check("to_sc", ifc.stall_cycles, 32'd12);
    clear_in();
    step("to_idle0", C_NONE);
    step("to_idle1", C_NONE);
    check("to_hold", {31'd0, ifc.mem_timeout}, 32'd1);
    rst = 1'b1;
    step("to_rst", C_NONE);
    rst = 1'b0;
    check("to_clr", {31'd0, ifc.mem_timeout}, 32'd0);

    // reset in the middle of a wait with stall_cycles=7
    set_load_use(5'd4);
    step("rw_lu0", C_LU);
    step("rw_lu1", C_LU);
    step("rw_lu2", C_LU);
    clear_in();
    ifc.mem_access = 1'b1;
    step("rw_m0", C_MEMST);
    step("rw_m1", C_MEMST);
    step("rw_m2", C_MEMST);
    step("rw_m3", C_MEMST);
    check("rw_sc7", ifc.stall_cycles, 32'd7);
    rst = 1'b1;
    step("rw_rst", C_NONE);
    rst = 1'b0;
    check("rw_sc0", ifc.stall_cycles, 32'd0);
    check("rw_to0", {31'd0, ifc.mem_timeout}, 32'd0);
    // fresh wait from IDLE: four stalls then the abort
    step("rw_n0", C_MEMST);
    step("rw_n1", C_MEMST);
    step("rw_n2", C_MEMST);
    step("rw_n3", C_MEMST);
    step("rw_n4", C_REQ);
    check("rw_to1", {31'd0, ifc.mem_timeout}, 32'd1);
    check("rw_sc4", ifc.stall_cycles, 32'd4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 255, maximum dmem wait cycles (1..255) before watchdog abort.
REQ-002 Port: clk  in  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: id_rs1, id_rs2  in  5 each  ID-stage source register addresses.
REQ-005 Port: id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads rs1/rs2.
REQ-006 Port: ex_rd  in  5; ex_reg_wen, ex_mem_ren, ex_branch_taken  in  1 each  EX-stage destination, load flag, redirect flag.
REQ-007 Port: mem_access  in  1  MEM-stage instruction is a load or store (mem_mem_ren|mem_mem_wen).
REQ-008 Port: dmem_ack  in  1  data memory completes the current access this cycle.
REQ-009 Port: dmem_req  out  1  data memory request, held until ack.
REQ-010 Port: stall_pc, stall_ifid, stall_idex, stall_exmem  out  1 each  hold the PC or pipeline register.
REQ-011 Port: flush_ifid, flush_idex, flush_memwb  out  1 each  clear the pipeline register to a bubble.
REQ-012 Port: mem_timeout  out  1  sticky watchdog error; stall_cycles  out  32  count of cycles with stall_pc=1.

Function
REQ-013 Memory FSM states: IDLE, WAIT; 8-bit wait_cnt.
REQ-014 IDLE: dmem_req=mem_access; if mem_access and !dmem_ack -> WAIT, wait_cnt<=1; otherwise stay IDLE.
REQ-015 WAIT: dmem_req=1; dmem_ack -> IDLE, wait_cnt<=0; else if wait_cnt==TIMEOUT -> IDLE, mem_timeout<=1, wait_cnt<=0; else wait_cnt<=wait_cnt+1.
REQ-016 mem_stall = (IDLE & mem_access & !dmem_ack) | (WAIT & !dmem_ack & wait_cnt!=TIMEOUT); combinational.
REQ-017 load_use = ex_mem_ren & ex_reg_wen & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-018 Priority: mem_stall > ex_branch_taken > load_use; exactly one case is applied per cycle.
REQ-019 mem_stall: stall_pc=stall_ifid=stall_idex=stall_exmem=1, flush_memwb=1, all other flushes 0; the redirect is kept pending in EX and applied on the first cycle without mem_stall.
REQ-020 Redirect (ex_branch_taken, no mem_stall): flush_ifid=flush_idex=1, all stalls 0; load_use ignored.
REQ-021 Load-use (no mem_stall, no redirect): stall_pc=stall_ifid=1, flush_idex=1, others 0; one-cycle bubble, after which the load is in MEM and load_use deasserts.
REQ-022 No hazard: all stall and flush outputs 0.
REQ-023 Stall and flush of the same register are never both 1.
REQ-024 stall_cycles increments by 1 each cycle stall_pc=1 and wraps 0xFFFFFFFF->0.
REQ-025 mem_timeout stays 1 until rst; after a timeout abort the pipeline advances as if acked.
REQ-026 The ack cycle itself does not stall; a back-to-back mem_access in the next cycle starts a new request from IDLE.

Reset
REQ-027 While rst=1: FSM<=IDLE, wait_cnt<=0, mem_timeout<=0, stall_cycles<=0; all stall, flush and dmem_req outputs are 0.
REQ-028 Reset asserted in WAIT aborts the access: dmem_req is 0 on the reset cycle and the state is IDLE afterward.

Verification
REQ-029 Load x5 in EX, ID reads rs1=5 with id_uses_rs1=1 -> one cycle of stall_pc=stall_ifid=flush_idex=1; stall_cycles=1; next cycle no stall.
REQ-030 Load with ex_rd=0 and ID rs1=0 -> no stall or flush.
REQ-031 mem_access=1, dmem_ack delayed 3 cycles -> dmem_req=1 and stall_exmem=flush_memwb=1 for 3 cycles; on the ack cycle stalls=0 and the FSM returns to IDLE.
REQ-032 ex_branch_taken=1 and load_use=1 during a 2-cycle mem wait -> 2 stall cycles with no flush_ifid, then one cycle of flush_ifid=flush_idex=1 and no stall.
REQ-033 TIMEOUT=4, dmem_ack never arrives -> stall for 4 cycles, abort on the 5th with mem_timeout=1 held until rst.
REQ-034 rst pulsed mid-WAIT with stall_cycles=7 -> the cycle after rst has dmem_req=0, stall_cycles=0, mem_timeout=0, and the FSM in IDLE.
